// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_BYTE_BITS = 8;

    function automatic logic even_parity(input logic [UART_BYTE_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Valid/ready word handshake feeding the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  parity_per_byte;

    modport master (
        output in_valid,
        output data_in,
        output parity_per_byte,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  data_in,
        input  parity_per_byte,
        output in_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART serialiser: start, LSB-first data, even parity per byte or per word, stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus,
    output logic      tx_out,
    output logic      busy,
    output logic      done
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] ALL_BITS  = CW'(DATA_WIDTH);
    localparam logic [2:0]    BYTE_LAST = 3'(UART_BYTE_BITS - 1);

    tx_state_t             state_q, state_n;
    logic [DATA_WIDTH-1:0] shift_q, shift_n;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_n;
    logic [2:0]            byte_cnt_q, byte_cnt_n;
    logic                  acc_q, acc_n;
    logic                  ppb_q, ppb_n;
    logic                  tx_q, tx_n;
    logic                  accept;

    assign bus.in_ready = (state_q == IDLE) || (state_q == STOP);
    assign accept       = bus.in_valid && bus.in_ready;
    assign tx_out       = tx_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == STOP);

    always_comb begin
        state_n    = state_q;
        shift_n    = shift_q;
        bit_cnt_n  = bit_cnt_q;
        byte_cnt_n = byte_cnt_q;
        acc_n      = acc_q;
        ppb_n      = ppb_q;
        tx_n       = 1'b1;

        unique case (state_q)
            IDLE, STOP: state_n = accept ? START : IDLE;
            START:      state_n = DATA;
            DATA: begin
                bit_cnt_n  = bit_cnt_q + CW'(1);
                byte_cnt_n = byte_cnt_q + 3'd1;
                if ((ppb_q && byte_cnt_q == BYTE_LAST) || bit_cnt_q == LAST_BIT)
                    state_n = PARITY;
                else
                    state_n = DATA;
            end
            PARITY: begin
                byte_cnt_n = 3'd0;
                state_n    = (bit_cnt_q == ALL_BITS) ? STOP : DATA;
            end
            default: state_n = IDLE;
        endcase

        // tx_out is registered, so the line value is chosen for the state being entered
        case (state_n)
            START: begin
                tx_n       = 1'b0;
                shift_n    = bus.data_in;
                ppb_n      = bus.parity_per_byte;
                bit_cnt_n  = '0;
                byte_cnt_n = 3'd0;
                acc_n      = 1'b0;
            end
            DATA: begin
                tx_n    = shift_q[0];
                shift_n = shift_q >> 1;
                acc_n   = acc_q ^ shift_q[0];
            end
            PARITY: begin
                tx_n  = acc_q;
                acc_n = 1'b0;
            end
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= 3'd0;
            acc_q      <= 1'b0;
            ppb_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_n;
            shift_q    <= shift_n;
            bit_cnt_q  <= bit_cnt_n;
            byte_cnt_q <= byte_cnt_n;
            acc_q      <= acc_n;
            ppb_q      <= ppb_n;
            tx_q       <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 8- and 16-bit widths with a frame decoder model.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8_n, rst16_n;
    logic tx8, busy8, done8;
    logic tx16, busy16, done16;

    uart_tx_if #(.DATA_WIDTH(8))  b8 ();
    uart_tx_if #(.DATA_WIDTH(16)) b16 ();

    uart_tx #(.DATA_WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst8_n),
        .bus    (b8.slave),
        .tx_out (tx8),
        .busy   (busy8),
        .done   (done8)
    );

    uart_tx #(.DATA_WIDTH(16)) dut16 (
        .clk    (clk),
        .rst_n  (rst16_n),
        .bus    (b16.slave),
        .tx_out (tx16),
        .busy   (busy16),
        .done   (done16)
    );

    typedef struct {
        int          w;
        logic [15:0] d;
        logic        ppb;
        int          len;
        logic [31:0] seq;
    } vec_t;

    vec_t vecs[9];
    logic cap[0:63];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic ln(input int w);
        return (w == 16) ? tx16 : tx8;
    endfunction

    function automatic logic bsy(input int w);
        return (w == 16) ? busy16 : busy8;
    endfunction

    function automatic logic dn(input int w);
        return (w == 16) ? done16 : done8;
    endfunction

    function automatic logic rdy(input int w);
        return (w == 16) ? b16.in_ready : b8.in_ready;
    endfunction

    task automatic drive(input int w, input logic v, input logic [15:0] d,
                         input logic p);
        if (w == 16) begin
            b16.in_valid        = v;
            b16.data_in         = d;
            b16.parity_per_byte = p;
        end else begin
            b8.in_valid         = v;
            b8.data_in          = d[7:0];
            b8.parity_per_byte  = p;
        end
    endtask

    // Present a word, wait (bounded) for ready, then scramble inputs after the edge
    task automatic accept(input int w, input logic [15:0] d, input logic p);
        int k;
        drive(w, 1'b1, d, p);
        for (k = 0; k < 100; k++) begin
            if (rdy(w)) break;
            @(negedge clk);
        end
        if (k == 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        drive(w, 1'b0, ~d, ~p);
    endtask

    // Receiver model: start 0, LSB-first data, even parity, stop 1
    function automatic void decode(input int w, input logic p, input int off,
                                   input logic flip, output logic [15:0] data,
                                   output logic err);
        int   pos;
        logic acc;
        pos  = off;
        acc  = 1'b0;
        data = '0;
        err  = (cap[pos] !== 1'b0);
        pos++;
        for (int i = 0; i < w; i++) begin
            data[i] = cap[pos];
            acc     = acc ^ cap[pos];
            pos++;
            if ((p && (i % 8) == 7) || (!p && i == w - 1)) begin
                if ((cap[pos] ^ flip) !== acc) err = 1'b1;
                acc = 1'b0;
                pos++;
            end
        end
        if (cap[pos] !== 1'b1) err = 1'b1;
    endfunction

    task automatic run_frame(input int vi, input int w, input logic [15:0] d,
                             input logic p, input int len,
                             input logic [31:0] seq);
        logic [15:0] rd;
        logic        re;
        @(negedge clk);
        accept(w, d, p);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            cap[i] = ln(w);
            check($sformatf("v%0d_bit%0d", vi, i), 32'(ln(w)),
                  32'(seq[len-1-i]));
            check($sformatf("v%0d_done%0d", vi, i), 32'(dn(w)),
                  32'(i == len - 1));
            if (i == 0) check($sformatf("v%0d_busy", vi), 32'(bsy(w)), 32'd1);
        end
        @(negedge clk);
        check($sformatf("v%0d_idle_tx", vi), 32'(ln(w)), 32'd1);
        check($sformatf("v%0d_idle_busy", vi), 32'(bsy(w)), 32'd0);
        decode(w, p, 0, 1'b0, rd, re);
        check($sformatf("v%0d_rx_data", vi), 32'(rd), 32'(d));
        check($sformatf("v%0d_rx_err", vi), 32'(re), 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        logic        re;
        logic [31:0] s;

        vecs[0] = '{8,  16'h00A5, 1'b0, 11, 'b0_10100101_0_1};
        vecs[1] = '{8,  16'h0000, 1'b0, 11, 'b0_00000000_0_1};
        vecs[2] = '{8,  16'h0001, 1'b1, 11, 'b0_10000000_1_1};
        vecs[3] = '{8,  16'h00FF, 1'b0, 11, 'b0_11111111_0_1};
        vecs[4] = '{8,  16'h0080, 1'b0, 11, 'b0_00000001_1_1};
        vecs[5] = '{16, 16'h0701, 1'b1, 20, 'b0_10000000_1_11100000_1_1};
        vecs[6] = '{16, 16'h0701, 1'b0, 19, 'b0_10000000_11100000_0_1};
        vecs[7] = '{16, 16'hFFFF, 1'b1, 20, 'b0_11111111_0_11111111_0_1};
        vecs[8] = '{16, 16'h8001, 1'b0, 19, 'b0_10000000_00000001_0_1};

        rst8_n  = 1'b0;
        rst16_n = 1'b0;
        drive(8, 1'b0, 16'h0, 1'b0);
        drive(16, 1'b0, 16'h0, 1'b0);
        #12;
        check("rst_tx8", 32'(tx8), 32'd1);
        check("rst_ready8", 32'(b8.in_ready), 32'd1);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_tx16", 32'(tx16), 32'd1);
        check("rst_ready16", 32'(b16.in_ready), 32'd1);
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_done16", 32'(done16), 32'd0);
        @(negedge clk);
        rst8_n  = 1'b1;
        rst16_n = 1'b1;

        for (int vi = 0; vi < 9; vi++) begin
            run_frame(vi, vecs[vi].w, vecs[vi].d, vecs[vi].ppb,
                      vecs[vi].len, vecs[vi].seq);
            if (vi == 0) begin
                decode(8, 1'b0, 0, 1'b1, rd, re);
                check("flip_parity_err", 32'(re), 32'd1);
            end
        end

        // Back-to-back: 0x3C then 0xFF with in_valid held high
        s = 'b0_00111100_0_1_0_11111111_0_1;
        @(negedge clk);
        drive(8, 1'b1, 16'h003C, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b1, 16'h00FF, 1'b0);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            cap[i] = tx8;
            check($sformatf("b2b_bit%0d", i), 32'(tx8), 32'(s[21-i]));
            check($sformatf("b2b_ready%0d", i), 32'(b8.in_ready),
                  32'(i == 10 || i == 21));
            check($sformatf("b2b_done%0d", i), 32'(done8),
                  32'(i == 10 || i == 21));
            if (i == 10) begin
                @(posedge clk);
                #1;
                drive(8, 1'b0, 16'h0, 1'b0);
            end
        end
        decode(8, 1'b0, 0, 1'b0, rd, re);
        check("b2b_rx0_data", 32'(rd), 32'h3C);
        check("b2b_rx0_err", 32'(re), 32'd0);
        decode(8, 1'b0, 11, 1'b0, rd, re);
        check("b2b_rx1_data", 32'(rd), 32'hFF);
        check("b2b_rx1_err", 32'(re), 32'd0);
        @(negedge clk);
        check("b2b_idle", 32'(busy8), 32'd0);

        // Reset while data bit 4 of 0x55 is on the line
        s = 'b0_10101;
        @(negedge clk);
        accept(8, 16'h0055, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rstmid_bit%0d", i), 32'(tx8), 32'(s[5-i]));
        end
        #2;
        rst8_n = 1'b0;
        #1;
        check("rstmid_tx", 32'(tx8), 32'd1);
        check("rstmid_busy", 32'(busy8), 32'd0);
        check("rstmid_done", 32'(done8), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rsthold_tx%0d", i), 32'(tx8), 32'd1);
            check($sformatf("rsthold_done%0d", i), 32'(done8), 32'd0);
        end
        rst8_n = 1'b1;
        run_frame(9, 8, 16'h0012, 1'b0, 11, 'b0_01001000_0_1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that produces the one-bit-per-clock UART frame consumed by the team's receiver (`rx_asm`). It accepts a parallel word over a valid/ready handshake and serialises it LSB first: start bit, data bits, even-parity bit(s), stop bit. Parity goes either after every byte or once after the whole word. It sits directly upstream of the receiver, and `tx_out` connects straight to `rx_in` in loopback benches.

## Interface
- `DATA_WIDTH`, default 8: payload width in bits. Must be ≥ 2. Must be a multiple of 8 whenever `parity_per_byte` is used.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: `data_in` holds a word to send.
- `in_ready` output, 1 bit: the block can accept a word this cycle.
- `data_in` input, `DATA_WIDTH` bits: payload, sampled on acceptance.
- `parity_per_byte` input, 1 bit, sampled on acceptance:
  - 1: one parity bit after each 8 data bits.
  - 0: one parity bit after all `DATA_WIDTH` bits.
- `tx_out` output, 1 bit: serial line, registered, idles high.
- `busy` output, 1 bit: a frame is in progress (any state other than IDLE).
- `done` output, 1 bit: one-cycle pulse while the stop bit is on the line.

## Operation
- Acceptance happens on a rising edge where `in_valid && in_ready`. On acceptance the block latches `data_in` into a shift register and latches `parity_per_byte`, then enters START.
- `in_ready` = (state == IDLE) || (state == STOP). Accepting in STOP gives back-to-back frames with no idle gap.
- States and line values:
  - IDLE: `tx_out`=1. On acceptance, go to START.
  - START: `tx_out`=0 for 1 cycle, then DATA.
  - DATA: `tx_out` = shift_reg[0]. Each cycle shift right and increment `bit_cnt` and `byte_bit_cnt`.
    - Go to PARITY when `parity_per_byte` is latched and `byte_bit_cnt`==7.
    - Otherwise go to PARITY when `bit_cnt`==DATA_WIDTH-1.
    - Otherwise stay in DATA.
  - PARITY: `tx_out` = XOR of the bits just sent (that byte, or the whole word). Clear `byte_bit_cnt`. Go to STOP if all `DATA_WIDTH` bits have been sent, else back to DATA.
  - STOP: `tx_out`=1 for 1 cycle and `done`=1. On acceptance go to START, else IDLE.
- Parity is even. The parity bit equals the XOR of the covered data bits; this matches the receiver's check `rx_in == ^data`.
- Parity tracking uses a running 1-bit accumulator. It XORs in each data bit as it is sent, is reset after each parity bit, and is cleared at START.
- Counter widths:
  - `bit_cnt`: $clog2(DATA_WIDTH)+1 bits.
  - `byte_bit_cnt`: 3 bits, wraps 7→0.
  - No counter may overflow for DATA_WIDTH ≤ 64.
- `data_in` and `parity_per_byte` changing mid-frame have no effect on the frame in progress.

## Timing
- Reset values: state=IDLE, `tx_out`=1, `in_ready`=1, `busy`=0, `done`=0. Counters, parity accumulator and shift register are all 0.
- Reset mid-frame: `tx_out` goes to 1 asynchronously and the frame is abandoned. No `done` pulse is produced.
- Latency: if the word is accepted at edge T, the start bit is on `tx_out` during cycle T+1. The first data bit follows at T+2.
- Frame length:
  - Whole-word parity: `DATA_WIDTH`+3 cycles.
  - Per-byte parity: `DATA_WIDTH` + `DATA_WIDTH`/8 + 2 cycles.
- Receiver alignment: the receiver sees the start bit in its idle state and samples data on the following cycles. The parity bit lands in its checker state and the stop bit in its stop state. The receiver is back in idle the cycle after the stop bit, so back-to-back frames are legal.
- `in_valid` held high with `in_ready` low: the word is not consumed and must stay stable until accepted.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - Constant `UART_BYTE_BITS` = 8.
  - Function `even_parity(byte)`.
- Single module. No sub-module is needed; the shift register, counters and FSM are small enough to sit together.

## Test plan
- Reset, then `DATA_WIDTH`=8, whole-word parity, send 0xA5 → `tx_out` over 11 cycles reads 0,1,0,1,0,0,1,0,1,0,1, with `done` high on cycle 11. Loopback into `rx_asm` gives `valid`=1, `data`=0xA5, `error`=0.
- `DATA_WIDTH`=16, per-byte parity, send 0x0701 → `tx_out` reads 0, 1,0,0,0,0,0,0,0, 1, 1,1,1,0,0,0,0,0, 1, 1 (20 cycles). Loopback gives `data`=0x0701, `error`=0.
- Back-to-back: hold `in_valid` high with 0x3C then 0xFF → second start bit directly follows the first stop bit with no idle cycle. `in_ready` is high only in IDLE/STOP. Both words are received error-free.
- `rst_n` asserted at data bit 4 of 0x55 → `tx_out`=1 immediately and `busy`=0. After release, a new send of 0x12 produces a correct frame.
- Change `data_in` and `parity_per_byte` mid-frame → transmitted bits unchanged from the values latched at acceptance.
- Error injection: flip the parity bit on the line in loopback → receiver reports `error`=1. Confirms the bench checks the parity position.
